mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction cache (client ic) and the data cache (client dc).
- Grants one client at a time and locks the grant for a whole cache-line transaction: one request handshake, plus BEATS write-data beats or BEATS read-response beats.
- Routes responses only to the owner.
- Arbitration is round-robin by default.
- Sits between both cache instances and the memory model or top-level memory port.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 33 +++
 rtl/mem_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: owner and state encodings,
// default geometry of a cache-line transaction, and a grant decode helper.
// Optional build macro used by this block: MEM_ARB_DC_PRIORITY_EN.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    localparam int MEM_ADDR_BITS = 28;
    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_BEATS     = 4;
    localparam int MEM_BEAT_BITS = $clog2(MEM_BEATS);

    // One-hot grant {dc, ic} to owner encoding.
    function automatic logic owner_of(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input picker: bit 0 = ic, bit 1 = dc. A lone requester always wins.
// On a tie, round-robin hands the grant to the client that did not win last;
// with MEM_ARB_DC_PRIORITY_EN defined, dc wins every tie instead.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Resolve the one-hot grant from the request pair.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef MEM_ARB_DC_PRIORITY_EN
                grant = 2'b10;
`else
                if (last_grant == OWNER_DC) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the instruction cache (ic) and the
// data cache (dc). A grant is held for a whole line transaction: one request
// handshake plus BEATS write beats or BEATS read responses. Arbitration takes
// one IDLE cycle. Optional build macro: MEM_ARB_DC_PRIORITY_EN (dc wins ties).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = MEM_ADDR_BITS,
    parameter int DATA_BITS = MEM_DATA_BITS,
    parameter int BEATS     = MEM_BEATS
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_mem_req_valid,
    output logic                   ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic                   ic_mem_req_rw,
    input  logic                   ic_mem_req_data_valid,
    output logic                   ic_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
    output logic                   ic_mem_resp_valid,
    output logic [DATA_BITS-1:0]   ic_mem_resp_data,

    input  logic                   dc_mem_req_valid,
    output logic                   dc_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                   dc_mem_req_rw,
    input  logic                   dc_mem_req_data_valid,
    output logic                   dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                   dc_mem_resp_valid,
    output logic [DATA_BITS-1:0]   dc_mem_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int BEAT_W = $clog2(BEATS);

    arb_state_e        state_r, state_n;
    logic              owner_r, owner_n;
    logic              req_done_r, req_done_n;
    // Set once all write beats have fired; lets beats finish ahead of the
    // request handshake even though the beat counter has wrapped to 0.
    logic              data_done_r, data_done_n;
    logic              rw_r, rw_n;
    logic [BEAT_W-1:0] beat_r, beat_n;
    logic              last_grant_r, last_grant_n;

    logic [1:0]           grant_s;
    logic                 own_req_valid_s;
    logic [ADDR_BITS-1:0] own_addr_s;
    logic                 own_rw_s;
    logic                 own_data_valid_s;
    logic [DATA_BITS-1:0] own_data_bits_s;
    logic [DATA_BITS/8-1:0] own_data_mask_s;
    logic                 eff_rw_s;
    logic                 req_fire_s;
    logic                 data_fire_s;
    logic                 resp_beat_s;
    logic                 last_beat_s;
    logic                 write_done_s;
    logic                 read_done_s;
    logic                 txn_done_s;

    rr_arbiter2 u_pick (
        .req        ({dc_mem_req_valid, ic_mem_req_valid}),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Select the current owner's request and write-data channels.
    always_comb begin
        if (owner_r == OWNER_DC) begin
            own_req_valid_s  = dc_mem_req_valid;
            own_addr_s       = dc_mem_req_addr;
            own_rw_s         = dc_mem_req_rw;
            own_data_valid_s = dc_mem_req_data_valid;
            own_data_bits_s  = dc_mem_req_data_bits;
            own_data_mask_s  = dc_mem_req_data_mask;
        end else begin
            own_req_valid_s  = ic_mem_req_valid;
            own_addr_s       = ic_mem_req_addr;
            own_rw_s         = ic_mem_req_rw;
            own_data_valid_s = ic_mem_req_data_valid;
            own_data_bits_s  = ic_mem_req_data_bits;
            own_data_mask_s  = ic_mem_req_data_mask;
        end
    end

    // Before the request handshake the owner's live rw decides whether write
    // beats may flow; afterwards the latched direction is authoritative.
    assign eff_rw_s     = req_done_r ? rw_r : own_rw_s;
    assign req_fire_s   = mem_req_valid && mem_req_ready;
    assign data_fire_s  = mem_req_data_valid && mem_req_data_ready;
    assign resp_beat_s  = (state_r == BUSY) && req_done_r && !rw_r && mem_resp_valid;
    assign last_beat_s  = (beat_r == BEAT_W'(BEATS - 1));
    assign write_done_s = eff_rw_s && (req_done_r || req_fire_s)
                          && (data_done_r || (data_fire_s && last_beat_s));
    assign read_done_s  = resp_beat_s && last_beat_s;
    assign txn_done_s   = (state_r == BUSY) && (write_done_s || read_done_s);

    // Drive the memory side: owner's channels while BUSY, quiet while IDLE.
    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        if (state_r == BUSY) begin
            mem_req_valid      = own_req_valid_s && !req_done_r;
            mem_req_addr       = own_addr_s;
            mem_req_rw         = own_rw_s;
            mem_req_data_valid = eff_rw_s && !data_done_r && own_data_valid_s;
            mem_req_data_bits  = own_data_bits_s;
            mem_req_data_mask  = own_data_mask_s;
        end else begin
            mem_req_valid      = 1'b0;
            mem_req_data_valid = 1'b0;
        end
    end

    // Route handshakes and responses back to the owner only.
    always_comb begin
        ic_mem_req_ready      = req_fire_s  && (owner_r == OWNER_IC);
        ic_mem_req_data_ready = data_fire_s && (owner_r == OWNER_IC);
        ic_mem_resp_valid     = resp_beat_s && (owner_r == OWNER_IC);
        dc_mem_req_ready      = req_fire_s  && (owner_r == OWNER_DC);
        dc_mem_req_data_ready = data_fire_s && (owner_r == OWNER_DC);
        dc_mem_resp_valid     = resp_beat_s && (owner_r == OWNER_DC);
        ic_mem_resp_data      = mem_resp_data;
        dc_mem_resp_data      = mem_resp_data;
    end

    // Next-state logic for the grant FSM and its transaction bookkeeping.
    always_comb begin
        state_n      = state_r;
        owner_n      = owner_r;
        req_done_n   = req_done_r;
        data_done_n  = data_done_r;
        rw_n         = rw_r;
        beat_n       = beat_r;
        last_grant_n = last_grant_r;
        case (state_r)
            IDLE: begin
                if (|grant_s) begin
                    state_n     = BUSY;
                    owner_n     = owner_of(grant_s);
                    req_done_n  = 1'b0;
                    data_done_n = 1'b0;
                    beat_n      = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (req_fire_s) begin
                    req_done_n = 1'b1;
                    rw_n       = own_rw_s;
                end else begin
                    req_done_n = req_done_r;
                end
                if (data_fire_s || resp_beat_s) begin
                    beat_n = beat_r + BEAT_W'(1);
                end else begin
                    beat_n = beat_r;
                end
                if (data_fire_s && last_beat_s) begin
                    data_done_n = 1'b1;
                end else begin
                    data_done_n = data_done_r;
                end
                if (txn_done_s) begin
                    state_n      = IDLE;
                    last_grant_n = owner_r;
                    beat_n       = '0;
                    req_done_n   = 1'b0;
                    data_done_n  = 1'b0;
                end else begin
                    state_n = BUSY;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            owner_r      <= OWNER_IC;
            req_done_r   <= 1'b0;
            data_done_r  <= 1'b0;
            rw_r         <= 1'b0;
            beat_r       <= '0;
            last_grant_r <= OWNER_DC;
        end else begin
            state_r      <= state_n;
            owner_r      <= owner_n;
            req_done_r   <= req_done_n;
            data_done_r  <= data_done_n;
            rw_r         <= rw_n;
            beat_r       <= beat_n;
            last_grant_r <= last_grant_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model is compared
// against the DUT on every falling edge, and directed scenarios pin the model
// with hand-computed literals.
module tb_mem_arbiter;

    localparam int AB    = 28;
    localparam int DB    = 128;
    localparam int BEATS = 4;
`ifdef MEM_ARB_DC_PRIORITY_EN
    localparam bit DC_PRIO = 1'b1;
`else
    localparam bit DC_PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
    logic ic_mem_req_data_valid, ic_mem_req_data_ready, ic_mem_resp_valid;
    logic [AB-1:0] ic_mem_req_addr;
    logic [DB-1:0] ic_mem_req_data_bits, ic_mem_resp_data;
    logic [DB/8-1:0] ic_mem_req_data_mask;
    logic dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
    logic dc_mem_req_data_valid, dc_mem_req_data_ready, dc_mem_resp_valid;
    logic [AB-1:0] dc_mem_req_addr;
    logic [DB-1:0] dc_mem_req_data_bits, dc_mem_resp_data;
    logic [DB/8-1:0] dc_mem_req_data_mask;
    logic mem_req_valid, mem_req_ready, mem_req_rw;
    logic mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
    logic [AB-1:0] mem_req_addr;
    logic [DB-1:0] mem_req_data_bits, mem_resp_data;
    logic [DB/8-1:0] mem_req_data_mask;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
        .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
        .ic_mem_req_data_valid(ic_mem_req_data_valid), .ic_mem_req_data_ready(ic_mem_req_data_ready),
        .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
        .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
        .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
        .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
        .dc_mem_req_data_valid(dc_mem_req_data_valid), .dc_mem_req_data_ready(dc_mem_req_data_ready),
        .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
        .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int spurious = 0;

    // Transaction-level model state.
    bit model_on = 1'b0;
    bit m_busy, m_req_done, m_rw;
    int m_owner, m_beats, m_last;

    // Observations of the DUT for the literal checks.
    logic [DB-1:0]   ic_resp_q[$];
    logic [DB-1:0]   wdata_q[$];
    logic [DB/8-1:0] wmask_q[$];
    int              grant_q[$];
    int              dc_resp_cnt = 0;

    task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Compare the DUT against the model, log observations, advance the model.
    logic o_v, o_rw, o_dv, rw_eff, e_mrv, e_mdv, e_rf, e_df, e_rs;
    logic [AB-1:0] o_addr;
    logic [DB-1:0] o_bits;
    logic [DB/8-1:0] o_mask;
    int w;
    always @(negedge clk) begin
        if (m_owner == 1) begin
            o_v = dc_mem_req_valid; o_addr = dc_mem_req_addr; o_rw = dc_mem_req_rw;
            o_dv = dc_mem_req_data_valid; o_bits = dc_mem_req_data_bits; o_mask = dc_mem_req_data_mask;
        end else begin
            o_v = ic_mem_req_valid; o_addr = ic_mem_req_addr; o_rw = ic_mem_req_rw;
            o_dv = ic_mem_req_data_valid; o_bits = ic_mem_req_data_bits; o_mask = ic_mem_req_data_mask;
        end
        rw_eff = m_req_done ? m_rw : o_rw;
        e_mrv  = m_busy && o_v && !m_req_done;
        e_mdv  = m_busy && rw_eff && o_dv && (m_beats < BEATS);
        e_rf   = e_mrv && mem_req_ready;
        e_df   = e_mdv && mem_req_data_ready;
        e_rs   = m_busy && m_req_done && !m_rw && mem_resp_valid;
        if (model_on) begin
            chk("mem_req_valid", mem_req_valid, e_mrv);
            chk("mem_req_data_valid", mem_req_data_valid, e_mdv);
            chk("ic_req_ready", ic_mem_req_ready, e_rf && m_owner == 0);
            chk("dc_req_ready", dc_mem_req_ready, e_rf && m_owner == 1);
            chk("ic_data_ready", ic_mem_req_data_ready, e_df && m_owner == 0);
            chk("dc_data_ready", dc_mem_req_data_ready, e_df && m_owner == 1);
            chk("ic_resp_valid", ic_mem_resp_valid, e_rs && m_owner == 0);
            chk("dc_resp_valid", dc_mem_resp_valid, e_rs && m_owner == 1);
            chk("ic_resp_data", ic_mem_resp_data, mem_resp_data);
            chk("dc_resp_data", dc_mem_resp_data, mem_resp_data);
            if (e_mrv) begin
                chk("mem_req_addr", mem_req_addr, o_addr);
                chk("mem_req_rw", mem_req_rw, o_rw);
            end
            if (e_mdv) begin
                chk("mem_req_data_bits", mem_req_data_bits, o_bits);
                chk("mem_req_data_mask", mem_req_data_mask, o_mask);
            end
            if (ic_mem_resp_valid === 1'b1) ic_resp_q.push_back(ic_mem_resp_data);
            if (dc_mem_resp_valid === 1'b1) dc_resp_cnt++;
            if (mem_req_data_valid === 1'b1 && mem_req_data_ready) begin
                wdata_q.push_back(mem_req_data_bits);
                wmask_q.push_back(mem_req_data_mask);
            end
            if (ic_mem_req_ready === 1'b1) grant_q.push_back(0);
            if (dc_mem_req_ready === 1'b1) grant_q.push_back(1);
            if (reset && mem_resp_valid && !e_rs) begin
                spurious++;
                $display("note: protocol error, mem_resp_valid with no read awaiting data");
            end
        end
        if (!reset) begin
            model_on = 1'b1; m_busy = 1'b0; m_req_done = 1'b0; m_beats = 0; m_last = 1; m_owner = 0;
        end else if (model_on) begin
            if (!m_busy) begin
                if (ic_mem_req_valid || dc_mem_req_valid) begin
                    if (ic_mem_req_valid && dc_mem_req_valid)
                        w = DC_PRIO ? 1 : (m_last == 1 ? 0 : 1);
                    else
                        w = dc_mem_req_valid ? 1 : 0;
                    m_busy = 1'b1; m_owner = w; m_req_done = 1'b0; m_beats = 0;
                end
            end else begin
                if (e_rf) begin m_req_done = 1'b1; m_rw = o_rw; end
                if (e_df || e_rs) m_beats++;
                if (m_req_done && m_beats == BEATS) begin
                    m_busy = 1'b0; m_req_done = 1'b0; m_beats = 0; m_last = m_owner;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int c);
        return (c == 1) ? dc_mem_req_ready : ic_mem_req_ready;
    endfunction

    task automatic set_req(input int c, input logic v, input logic [AB-1:0] a, input logic rw);
        if (c == 1) begin
            dc_mem_req_valid = v; dc_mem_req_addr = a; dc_mem_req_rw = rw;
        end else begin
            ic_mem_req_valid = v; ic_mem_req_addr = a; ic_mem_req_rw = rw;
        end
    endtask

    task automatic resp_beats(input int n, input logic [DB-1:0] base);
        for (int b = 0; b < n; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + DB'(b);
            step();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    // Wait (bounded) for the request handshake, then let it fire and drop valid.
    task automatic get_grant(input int c, input logic [AB-1:0] a);
        int n;
        set_req(c, 1'b1, a, 1'b0);
        #1;
        n = 0;
        while (!rdy(c) && n < 20) begin step(); n++; end
        if (!rdy(c)) tmo("grant_wait");
        step();
        set_req(c, 1'b0, a, 1'b0);
    endtask

    logic [DB-1:0] wd [4];
    int exp_g [6];
    int rem [2];
    int k, cyc, n, who, sp0;
    bit req_pend, fr, fd;

    initial begin
        reset = 1'b0;
        ic_mem_req_valid = 0; ic_mem_req_addr = '0; ic_mem_req_rw = 0;
        ic_mem_req_data_valid = 0; ic_mem_req_data_bits = '0; ic_mem_req_data_mask = '0;
        dc_mem_req_valid = 0; dc_mem_req_addr = '0; dc_mem_req_rw = 0;
        dc_mem_req_data_valid = 0; dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
        mem_req_ready = 1'b1; mem_req_data_ready = 1'b0; mem_resp_valid = 0; mem_resp_data = '0;
        repeat (3) step();
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_data_valid", mem_req_data_valid, 1'b0);
        chk("rst_readies", {ic_mem_req_ready, dc_mem_req_ready, ic_mem_req_data_ready, dc_mem_req_data_ready}, 4'b0000);
        chk("rst_resp_valids", {ic_mem_resp_valid, dc_mem_resp_valid}, 2'b00);
        reset = 1'b1;
        step();

        // ic read of one line.
        ic_resp_q.delete(); grant_q.delete(); dc_resp_cnt = 0;
        get_grant(0, 28'h0000100);
        resp_beats(4, 128'hA);
        step();
        chk("t1_resp_count", ic_resp_q.size(), 4);
        for (int i = 0; i < 4 && i < ic_resp_q.size(); i++)
            chk("t1_resp_data", ic_resp_q[i], 128'hA + 128'(i));
        chk("t1_ready_pulses", grant_q.size(), 1);
        chk("t1_dc_resp", dc_resp_cnt, 0);
        chk("t1_idle", mem_req_valid, 1'b0);

        // dc write with data ready held low for the first three BUSY cycles.
        for (int i = 0; i < 4; i++) wd[i] = {4{32'hD000_0000 + 32'(i)}};
        wdata_q.delete(); wmask_q.delete(); grant_q.delete();
        set_req(1, 1'b1, 28'h0000200, 1'b1);
        dc_mem_req_data_valid = 1'b1; dc_mem_req_data_bits = wd[0]; dc_mem_req_data_mask = 16'hFFFF;
        mem_req_data_ready = 1'b0;
        k = 0; cyc = 0; req_pend = 1'b1; n = 0;
        while ((k < 4 || req_pend) && n < 40) begin
            #1;
            fr = dc_mem_req_ready; fd = dc_mem_req_data_ready;
            step();
            n++; cyc++;
            if (fr) begin dc_mem_req_valid = 1'b0; req_pend = 1'b0; end
            if (fd) begin
                k++;
                if (k < 4) dc_mem_req_data_bits = wd[k];
                else dc_mem_req_data_valid = 1'b0;
            end
            mem_req_data_ready = (cyc >= 4);
        end
        if (n >= 40) tmo("t2_write");
        mem_req_data_ready = 1'b0; dc_mem_req_rw = 1'b0;
        step();
        chk("t2_fire_count", wdata_q.size(), 4);
        for (int i = 0; i < 4 && i < wdata_q.size(); i++) begin
            chk("t2_wdata", wdata_q[i], wd[i]);
            chk("t2_wmask", wmask_q[i], 16'hFFFF);
        end
        chk("t2_grants", grant_q.size(), 1);

        // Both clients contend for three reads each.
        grant_q.delete();
        rem[0] = 3; rem[1] = 3;
        for (int g = 0; g < 8 && (rem[0] + rem[1]) > 0; g++) begin
            set_req(0, rem[0] > 0, 28'h0000300, 1'b0);
            set_req(1, rem[1] > 0, 28'h0000400, 1'b0);
            #1;
            n = 0;
            while (!(ic_mem_req_ready || dc_mem_req_ready) && n < 20) begin step(); n++; end
            if (!(ic_mem_req_ready || dc_mem_req_ready)) begin tmo("t3_grant"); break; end
            who = ic_mem_req_ready ? 0 : 1;
            step();
            set_req(who, 1'b0, 28'h0, 1'b0);
            resp_beats(4, 128'h100 * 128'(who + 1));
            rem[who]--;
        end
        set_req(0, 1'b0, 28'h0, 1'b0);
        set_req(1, 1'b0, 28'h0, 1'b0);
        step();
        if (DC_PRIO) begin
            exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 0; exp_g[4] = 0; exp_g[5] = 0;
        end else begin
            exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1; exp_g[4] = 0; exp_g[5] = 1;
        end
        chk("t3_grant_count", grant_q.size(), 6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++)
            chk("t3_grant_order", grant_q[i], exp_g[i]);

        // Spurious response while IDLE.
        sp0 = spurious;
        mem_resp_valid = 1'b1; mem_resp_data = 128'hBAD;
        #1;
        chk("t5_no_resp", {ic_mem_resp_valid, dc_mem_resp_valid}, 2'b00);
        step();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        #1;
        chk("t5_flagged", spurious - sp0, 1);
        chk("t5_still_idle", mem_req_valid, 1'b0);
        step();

        // Reset after the second read beat, then a clean read.
        get_grant(0, 28'h0000500);
        resp_beats(2, 128'h10);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_outputs_zero", {mem_req_valid, mem_req_data_valid, ic_mem_req_ready, dc_mem_req_ready,
            ic_mem_resp_valid, dc_mem_resp_valid, ic_mem_req_data_ready, dc_mem_req_data_ready}, 8'h00);
        ic_resp_q.delete();
        get_grant(0, 28'h0000600);
        resp_beats(4, 128'h20);
        step();
        chk("t6_resp_count", ic_resp_q.size(), 4);
        for (int i = 0; i < 4 && i < ic_resp_q.size(); i++)
            chk("t6_resp_data", ic_resp_q[i], 128'h20 + 128'(i));

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
